// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, oversampling tick and received-word signals of the UART receiver
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] dout;
  logic                 rx_done_tick;
  logic                 frame_err;

  modport master (
    output s_tick,
    output rx,
    input  dout,
    input  rx_done_tick,
    input  frame_err
  );

  modport slave (
    input  s_tick,
    input  rx,
    output dout,
    output rx_done_tick,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampled UART receiver: 1 start, DATA_BITS LSB-first, no parity, 1 stop
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  localparam int SW = $clog2(SB_TICKS);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_HALF = SW'(SB_TICKS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SB_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic [SW-1:0]        s, s_next;
  logic [NW-1:0]        n, n_next;
  logic [DATA_BITS-1:0] b, b_next;
  logic [DATA_BITS-1:0] dout_q, dout_next;
  logic                 done_q, done_next;
  logic                 ferr_q, ferr_next;
  logic                 rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state   <= IDLE;
      s       <= '0;
      n       <= '0;
      b       <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      state   <= state_next;
      s       <= s_next;
      n       <= n_next;
      b       <= b_next;
      dout_q  <= dout_next;
      done_q  <= done_next;
      ferr_q  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    dout_next  = dout_q;
    ferr_next  = ferr_q;
    done_next  = 1'b0;
    case (state)
      // Start detection does not wait for a tick so the half-bit count starts at the edge.
      IDLE: begin
        if (!rx_sync) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s == S_HALF) begin
            if (!rx_sync) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s == S_LAST) begin
            s_next = '0;
            b_next = {rx_sync, b[DATA_BITS-1:1]};
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
      STOP: begin
        if (bus.s_tick) begin
          if (s == S_LAST) begin
            state_next = IDLE;
            dout_next  = b;
            ferr_next  = ~rx_sync;
            done_next  = 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed 8N1/16x checks of uart_rx plus a 7-bit/8x scoreboard run
`timescale 1ns/1ps
module tb_uart_rx;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rx8   = 1'b1;
  logic rx7   = 1'b1;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   t0;

  typedef struct {
    logic [8:0] d;
    logic       fe;
    int         at;
  } rec_t;

  rec_t       got8[$];
  rec_t       got7[$];
  logic [6:0] exp7[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DATA_BITS(8)) if8 ();
  uart_rx_if #(.DATA_BITS(7)) if7 ();

  // Ticks are consumed on posedges where cyc becomes a multiple of 4.
  assign if8.rx     = rx8;
  assign if8.s_tick = (cyc % 4 == 3);
  assign if7.rx     = rx7;
  assign if7.s_tick = 1'b1;

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut8 (.clk(clk), .reset(reset), .bus(if8.slave));
  uart_rx #(.DATA_BITS(7), .SB_TICKS(8))  dut7 (.clk(clk), .reset(reset), .bus(if7.slave));

  always @(negedge clk) begin
    rec_t r;
    if (if8.rx_done_tick === 1'b1) begin
      r.d  = {1'b0, if8.dout};
      r.fe = if8.frame_err;
      r.at = cyc;
      got8.push_back(r);
    end
    if (if7.rx_done_tick === 1'b1) begin
      r.d  = {2'b00, if7.dout};
      r.fe = if7.frame_err;
      r.at = cyc;
      got7.push_back(r);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clk_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic align8();
    while (cyc % 4 != 1) clk_wait(1);
  endtask

  task automatic frame8(input logic [7:0] d, input logic stop);
    rx8 = 1'b0;
    clk_wait(64);
    for (int i = 0; i < 8; i++) begin
      rx8 = d[i];
      clk_wait(64);
    end
    rx8 = stop;
    clk_wait(64);
    rx8 = 1'b1;
  endtask

  task automatic frame7(input logic [6:0] d);
    rx7 = 1'b0;
    clk_wait(8);
    for (int i = 0; i < 7; i++) begin
      rx7 = d[i];
      clk_wait(8);
    end
    rx7 = 1'b1;
    clk_wait(8);
  endtask

  task automatic expect_one8(input string tag, input logic [7:0] d, input logic fe);
    check({tag, "_cnt"}, 32'(got8.size()), 32'd1);
    if (got8.size() > 0) begin
      check({tag, "_dout"}, 32'(got8[0].d), 32'(d));
      check({tag, "_ferr"}, 32'(got8[0].fe), 32'(fe));
    end
  endtask

  initial begin
    clk_wait(4);
    check("rst_dout8", 32'(if8.dout), 32'h0);
    check("rst_done8", 32'(if8.rx_done_tick), 32'h0);
    check("rst_ferr8", 32'(if8.frame_err), 32'h0);
    check("rst_dout7", 32'(if7.dout), 32'h0);
    reset = 1'b1;
    clk_wait(10);

    // Start edge at cyc = k with k%4 == 1 puts the stop sample at k+611.
    got8.delete();
    align8();
    t0 = cyc;
    frame8(8'h55, 1'b1);
    clk_wait(64);
    expect_one8("single", 8'h55, 1'b0);
    if (got8.size() > 0)
      check("single_lat", 32'(got8[0].at - t0 >= 604 && got8[0].at - t0 <= 612), 32'd1);

    got8.delete();
    align8();
    frame8(8'hA3, 1'b1);
    frame8(8'h0F, 1'b1);
    clk_wait(64);
    check("b2b_cnt", 32'(got8.size()), 32'd2);
    if (got8.size() > 1) begin
      check("b2b_dout0", 32'(got8[0].d), 32'hA3);
      check("b2b_ferr0", 32'(got8[0].fe), 32'h0);
      check("b2b_dout1", 32'(got8[1].d), 32'h0F);
      check("b2b_ferr1", 32'(got8[1].fe), 32'h0);
    end

    got8.delete();
    align8();
    frame8(8'hC4, 1'b0);
    clk_wait(64);
    expect_one8("ferr", 8'hC4, 1'b1);
    got8.delete();
    align8();
    frame8(8'h12, 1'b1);
    clk_wait(64);
    expect_one8("after_ferr", 8'h12, 1'b0);

    got8.delete();
    align8();
    rx8 = 1'b0;
    clk_wait(20);
    rx8 = 1'b1;
    clk_wait(128);
    check("glitch_cnt", 32'(got8.size()), 32'd0);
    check("glitch_dout", 32'(if8.dout), 32'h12);
    align8();
    frame8(8'h7E, 1'b1);
    clk_wait(64);
    expect_one8("after_glitch", 8'h7E, 1'b0);

    got8.delete();
    align8();
    fork
      frame8(8'hFF, 1'b1);
      begin
        clk_wait(64 * 4 + 20);
        reset = 1'b0;
        clk_wait(2);
        reset = 1'b1;
      end
    join
    clk_wait(64);
    check("rstmid_cnt", 32'(got8.size()), 32'd0);
    check("rstmid_dout", 32'(if8.dout), 32'h0);
    check("rstmid_ferr", 32'(if8.frame_err), 32'h0);
    align8();
    frame8(8'h81, 1'b1);
    clk_wait(64);
    expect_one8("after_rst", 8'h81, 1'b0);

    got7.delete();
    frame7(7'h5A);
    clk_wait(16);
    check("p7_cnt", 32'(got7.size()), 32'd1);
    if (got7.size() > 0) begin
      check("p7_dout", 32'(got7[0].d), 32'h5A);
      check("p7_ferr", 32'(got7[0].fe), 32'h0);
    end

    got7.delete();
    for (int i = 0; i < 300; i++) begin
      logic [6:0] d;
      d = 7'($urandom);
      exp7.push_back(d);
      frame7(d);
      clk_wait($urandom_range(0, 12));
    end
    clk_wait(16);
    check("rand_cnt", 32'(got7.size()), 32'(exp7.size()));
    for (int i = 0; i < exp7.size() && i < got7.size(); i++) begin
      check($sformatf("rand_dout_%0d", i), 32'(got7[i].d), 32'(exp7[i]));
      check($sformatf("rand_ferr_%0d", i), 32'(got7[i].fe), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
